fp_to_int_s1: RTL

//  First stage of the FP->int convert pipe (fcvt.{w,wu,l,lu}.{s,d}); feeds the second stage, which shifts, rounds and saturates.

---
 rtl/fp_to_int_s1.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fp_to_int_s1.sv
// -----------------------------------------------------------------------------
// fp_to_int_s1
//   First stage of the FP -> integer convert pipe (fcvt.{w,wu,l,lu}.{s,d}).
//   Unpacks an f32 or f64 operand into a double-format raw value, classifies
//   it (NaN / Inf / exponent out of range for the result width), picks the
//   left- or right-shift path for stage 2 and precomputes the shift amounts
//   and the overflow / invalid hints. Results sit in one valid/ready register.
//
// Ports
//   clock, reset           clock; asynchronous active-low reset
//   io_flush               drop the held entry and the op presented this cycle
//   io_in_valid/ready      upstream handshake
//   io_in_src/fmt/rm/op    operand (f32 NaN-boxed in [63:32]), 0=f32 1=f64,
//                          rounding mode, {64-bit result, signed}
//   io_out_valid/ready     downstream handshake
//   io_s1_*                registered stage-2 bundle
// -----------------------------------------------------------------------------
module fp_to_int_s1 (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_flush,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [63:0] io_in_src,
  input  logic        io_in_fmt,
  input  logic [2:0]  io_in_rm,
  input  logic [1:0]  io_in_op,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic        io_s1_raw_a_sign,
  output logic [10:0] io_s1_raw_a_exp,
  output logic [52:0] io_s1_raw_a_sig,
  output logic [2:0]  io_s1_rm,
  output logic [1:0]  io_s1_op,
  output logic        io_s1_sel_lpath,
  output logic        io_s1_exp_of,
  output logic        io_s1_iv_sel_max,
  output logic        io_s1_lpath_iv,
  output logic        io_s1_lpath_of,
  output logic [3:0]  io_s1_lpath_shamt,
  output logic [10:0] io_s1_rpath_shamt
);

  // Canonical f32 quiet NaN, substituted for any operand that is not NaN-boxed.
  localparam logic [31:0] F32_QNAN = 32'h7FC0_0000;

  // ---------------------------------------------------------------------------
  // Unpack into double format
  // ---------------------------------------------------------------------------
  logic [31:0] f32_bits;
  logic        sign_d;
  logic [10:0] exp_d;
  logic [51:0] frac_d;
  logic        exp_all_ones;
  logic        is_nan;
  logic        is_inf;

  assign f32_bits = (io_in_src[63:32] == 32'hFFFF_FFFF) ? io_in_src[31:0] : F32_QNAN;

  always_comb begin
    sign_d       = 1'b0;
    exp_d        = '0;
    frac_d       = '0;
    exp_all_ones = 1'b0;
    if (io_in_fmt) begin
      sign_d       = io_in_src[63];
      exp_d        = io_in_src[62:52];
      frac_d       = io_in_src[51:0];
      exp_all_ones = (io_in_src[62:52] == 11'h7FF);
    end else begin
      sign_d       = f32_bits[31];
      // Rebias 127 -> 1023; zero/subnormal keeps exponent 0.
      exp_d        = (f32_bits[30:23] == 8'h00) ? 11'd0 : ({3'b000, f32_bits[30:23]} + 11'd896);
      frac_d       = {f32_bits[22:0], 29'b0};
      exp_all_ones = (f32_bits[30:23] == 8'hFF);
    end
  end

  assign is_nan = exp_all_ones & (frac_d != '0);
  assign is_inf = exp_all_ones & (frac_d == '0);

  // ---------------------------------------------------------------------------
  // Classification and shift precompute
  // ---------------------------------------------------------------------------
  logic signed [11:0] e_unb;
  logic signed [11:0] lim;
  logic        [52:0] sig_d;
  logic        [10:0] lshift_full;
  logic        [10:0] rpath_shamt_d;
  logic               sel_lpath_d;
  logic               exp_of_d;
  logic               iv_sel_max_d;
  logic               lpath_iv_d;
  logic               lpath_of_d;

  assign sig_d         = {exp_d != 11'd0, frac_d};
  assign e_unb         = $signed({1'b0, exp_d}) - 12'sd1023;
  assign lim           = io_in_op[1] ? 12'sd64 : 12'sd32;
  assign exp_of_d      = is_nan | is_inf | (e_unb >= lim);
  assign sel_lpath_d   = (exp_d >= 11'd1075);
  assign lshift_full   = exp_d - 11'd1075;
  // Subnormals shift as if exponent were 1; values on the left path wrap
  // here but stage 2 ignores rpath_shamt when sel_lpath is set.
  assign rpath_shamt_d = (exp_d == 11'd0) ? 11'd1074 : (11'd1075 - exp_d);
  assign lpath_iv_d    = ~io_in_op[0] & sign_d;
  // -2^63 is the one exponent-63 value that still fits a signed 64-bit result.
  assign lpath_of_d    = io_in_op[0] & (e_unb == 12'sd63) & ~(sign_d & (frac_d == '0));
  assign iv_sel_max_d  = is_nan | ~sign_d;

  // ---------------------------------------------------------------------------
  // Pipeline register
  // ---------------------------------------------------------------------------
  logic        valid_q;
  logic        fire;
  logic        sign_q;
  logic [10:0] exp_q;
  logic [52:0] sig_q;
  logic [2:0]  rm_q;
  logic [1:0]  op_q;
  logic        sel_lpath_q;
  logic        exp_of_q;
  logic        iv_sel_max_q;
  logic        lpath_iv_q;
  logic        lpath_of_q;
  logic [3:0]  lpath_shamt_q;
  logic [10:0] rpath_shamt_q;

  assign io_in_ready = ~valid_q | io_out_ready;
  assign fire        = io_in_valid & io_in_ready & ~io_flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else if (io_flush) begin
      valid_q <= 1'b0;
    end else if (fire) begin
      valid_q <= 1'b1;
    end else if (io_out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sign_q        <= 1'b0;
      exp_q         <= '0;
      sig_q         <= '0;
      rm_q          <= '0;
      op_q          <= '0;
      sel_lpath_q   <= 1'b0;
      exp_of_q      <= 1'b0;
      iv_sel_max_q  <= 1'b0;
      lpath_iv_q    <= 1'b0;
      lpath_of_q    <= 1'b0;
      lpath_shamt_q <= '0;
      rpath_shamt_q <= '0;
    end else if (fire) begin
      sign_q        <= sign_d;
      exp_q         <= exp_d;
      sig_q         <= sig_d;
      rm_q          <= io_in_rm;
      op_q          <= io_in_op;
      sel_lpath_q   <= sel_lpath_d;
      exp_of_q      <= exp_of_d;
      iv_sel_max_q  <= iv_sel_max_d;
      lpath_iv_q    <= lpath_iv_d;
      lpath_of_q    <= lpath_of_d;
      lpath_shamt_q <= lshift_full[3:0];
      rpath_shamt_q <= rpath_shamt_d;
    end
  end

  assign io_out_valid      = valid_q;
  assign io_s1_raw_a_sign  = sign_q;
  assign io_s1_raw_a_exp   = exp_q;
  assign io_s1_raw_a_sig   = sig_q;
  assign io_s1_rm          = rm_q;
  assign io_s1_op          = op_q;
  assign io_s1_sel_lpath   = sel_lpath_q;
  assign io_s1_exp_of      = exp_of_q;
  assign io_s1_iv_sel_max  = iv_sel_max_q;
  assign io_s1_lpath_iv    = lpath_iv_q;
  assign io_s1_lpath_of    = lpath_of_q;
  assign io_s1_lpath_shamt = lpath_shamt_q;
  assign io_s1_rpath_shamt = rpath_shamt_q;

endmodule
